lsu_bus_bridge: RTL and testbench



---
 rtl/lsu_bus_bridge_pkg.sv | 33 +++
 rtl/lsu_bus_bridge_if.sv | 66 ++++++
 rtl/lsu_bus_bridge.sv | 178 +++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus_bridge_pkg
//  Description : Shared types and constants for the load/store bus bridge.
//  Revision    : 1.0 - initial release
// ============================================================================

package lsu_bus_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef logic [1:0] resp_t;

    localparam resp_t       RESP_OKAY   = 2'b00;
    localparam resp_t       RESP_SLVERR = 2'b10;

    // Clears the byte-in-dword offset; narrowed to ADDR_W at the point of use.
    localparam logic [63:0] ALIGN_MASK  = 64'hFFFF_FFFF_FFFF_FFF8;

    function automatic logic resp_is_err(input resp_t resp);
        return resp != RESP_OKAY;
    endfunction

endpackage : lsu_bus_bridge_pkg

`default_nettype wire

// File: rtl/lsu_bus_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus_bridge_if
//  Description : Five-channel valid/ready memory bus between bridge and xbar.
//  Revision    : 1.0 - initial release
// ============================================================================

interface lsu_bus_bridge_if
    import lsu_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();

    // read address
    logic                  ar_valid_o;
    logic                  ar_ready_i;
    logic [ADDR_W-1:0]     ar_addr_o;
    // read data
    logic                  r_valid_i;
    logic                  r_ready_o;
    logic [DATA_W-1:0]     r_data_i;
    resp_t                 r_resp_i;
    // write address
    logic                  aw_valid_o;
    logic                  aw_ready_i;
    logic [ADDR_W-1:0]     aw_addr_o;
    // write data
    logic                  w_valid_o;
    logic                  w_ready_i;
    logic [DATA_W-1:0]     w_data_o;
    logic [DATA_W/8-1:0]   w_strb_o;
    // write response
    logic                  b_valid_i;
    logic                  b_ready_o;
    resp_t                 b_resp_i;

    modport master (
        output ar_valid_o, ar_addr_o,
        input  ar_ready_i,
        input  r_valid_i, r_data_i, r_resp_i,
        output r_ready_o,
        output aw_valid_o, aw_addr_o,
        input  aw_ready_i,
        output w_valid_o, w_data_o, w_strb_o,
        input  w_ready_i,
        input  b_valid_i, b_resp_i,
        output b_ready_o
    );

    modport slave (
        input  ar_valid_o, ar_addr_o,
        output ar_ready_i,
        output r_valid_i, r_data_i, r_resp_i,
        input  r_ready_o,
        input  aw_valid_o, aw_addr_o,
        output aw_ready_i,
        input  w_valid_o, w_data_o, w_strb_o,
        output w_ready_i,
        output b_valid_i, b_resp_i,
        input  b_ready_o
    );

endinterface : lsu_bus_bridge_if

`default_nettype wire

// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus_bridge
//  Description : Sequential LSU-to-bus bridge; one access in flight, core
//                stalled until the bus transaction completes.
//  Revision    : 1.0 - initial release
// ============================================================================

module lsu_bus_bridge
    import lsu_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  wire logic                 clk,
    input  wire logic                 rst,

    input  wire logic                 lsu_ren_i,
    input  wire logic                 lsu_wen_i,
    input  wire logic [ADDR_W-1:0]    lsu_addr_i,
    input  wire logic [DATA_W-1:0]    lsu_wdata_i,
    input  wire logic [DATA_W/8-1:0]  lsu_wmask_i,
    output logic      [DATA_W-1:0]    lsu_rdata_o,

    output logic                      mem_stall_o,
    output logic                      mem_err_o,

    lsu_bus_bridge_if.master          bus
);

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W/8-1:0]    r_strb;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_ar_valid;
    logic                   r_r_ready;
    logic                   r_aw_valid;
    logic                   r_w_valid;
    logic                   r_b_ready;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic                   r_err;

    logic [ADDR_W-1:0]      w_addr_aligned;
    logic [DATA_W-1:0]      w_wdata_sh;
    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_aw_fin;
    logic                   w_w_fin;
    logic                   w_busy;

    assign w_addr_aligned = lsu_addr_i & ALIGN_MASK[ADDR_W-1:0];
    // Store data arrives unshifted; move it onto the byte lanes its strobes select.
    assign w_wdata_sh     = lsu_wdata_i << {lsu_addr_i[2:0], 3'b000};

    assign w_ar_hs  = r_ar_valid & bus.ar_ready_i;
    assign w_r_hs   = r_r_ready  & bus.r_valid_i;
    assign w_aw_hs  = r_aw_valid & bus.aw_ready_i;
    assign w_w_hs   = r_w_valid  & bus.w_ready_i;
    assign w_b_hs   = r_b_ready  & bus.b_valid_i;

    // A channel counts as finished if it handshook earlier or is handshaking now.
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done  | w_w_hs;

    assign w_busy   = (r_state == ST_RADDR) || (r_state == ST_RDATA) ||
                      (r_state == ST_WREQ)  || (r_state == ST_WRESP);

    // Combinational so the core freezes in the very cycle it issues the request.
    assign mem_stall_o = ((r_state == ST_IDLE) && (lsu_ren_i || lsu_wen_i)) || w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_rdata    <= '0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_b_ready  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lsu_wen_i) begin
                        r_addr     <= w_addr_aligned;
                        r_wdata    <= w_wdata_sh;
                        r_strb     <= lsu_wmask_i;
                        r_aw_valid <= 1'b1;
                        r_w_valid  <= 1'b1;
                        r_state    <= ST_WREQ;
                    end else if (lsu_ren_i) begin
                        r_addr     <= w_addr_aligned;
                        r_ar_valid <= 1'b1;
                        r_state    <= ST_RADDR;
                    end
                end

                ST_RADDR: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= ST_RDATA;
                    end
                end

                ST_RDATA: begin
                    if (w_r_hs) begin
                        r_r_ready <= 1'b0;
                        r_rdata   <= resp_is_err(bus.r_resp_i) ? '0 : bus.r_data_i;
                        r_err     <= resp_is_err(bus.r_resp_i);
                        r_state   <= ST_DONE;
                    end
                end

                ST_WREQ: begin
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_b_ready <= 1'b1;
                        r_state   <= ST_WRESP;
                    end
                end

                ST_WRESP: begin
                    if (w_b_hs) begin
                        r_b_ready <= 1'b0;
                        r_err     <= resp_is_err(bus.b_resp_i);
                        r_state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_err     <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ar_valid_o = r_ar_valid;
    assign bus.ar_addr_o  = r_addr;
    assign bus.r_ready_o  = r_r_ready;
    assign bus.aw_valid_o = r_aw_valid;
    assign bus.aw_addr_o  = r_addr;
    assign bus.w_valid_o  = r_w_valid;
    assign bus.w_data_o   = r_wdata;
    assign bus.w_strb_o   = r_strb;
    assign bus.b_ready_o  = r_b_ready;

    assign lsu_rdata_o    = r_rdata;
    // The error flag is only ever set on the way into DONE and cleared on the way out.
    assign mem_err_o      = r_err;

endmodule : lsu_bus_bridge

`default_nettype wire

// File: tb/tb_lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_bus_bridge
//  Description : Randomised self-checking bench for lsu_bus_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_lsu_bus_bridge;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        stall;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] m_rdata;

    always #5 clk = ~clk;

    lsu_bus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    lsu_bus_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .lsu_ren_i   (ren),
        .lsu_wen_i   (wen),
        .lsu_addr_i  (addr),
        .lsu_wdata_i (wdata),
        .lsu_wmask_i (wmask),
        .lsu_rdata_o (rdata),
        .mem_stall_o (stall),
        .mem_err_o   (err),
        .bus         (bus_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] align8(input logic [63:0] a);
        return a - (a % 64'd8);
    endfunction

    // Byte i of the store data lands on lane (i + byte offset); lanes past 7 are lost.
    function automatic logic [63:0] place_bytes(input logic [63:0] d, input logic [63:0] a);
        logic [63:0] res;
        int          off;
        res = '0;
        off = int'(a % 64'd8);
        for (int i = 0; i + off < 8; i++) res[(i + off) * 8 +: 8] = d[i * 8 +: 8];
        return res;
    endfunction

    task automatic bus_quiet();
        bus_if.ar_ready_i = 1'b0;
        bus_if.r_valid_i  = 1'b0;
        bus_if.r_data_i   = '0;
        bus_if.r_resp_i   = 2'b00;
        bus_if.aw_ready_i = 1'b0;
        bus_if.w_ready_i  = 1'b0;
        bus_if.b_valid_i  = 1'b0;
        bus_if.b_resp_i   = 2'b00;
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ren = 1'b0;
            wen = 1'b0;
            bus_quiet();
            #1;
            check("gap_stall", stall, 0);
            check("gap_err", err, 0);
        end
    endtask

    task automatic do_load(input logic [63:0] a, input logic [63:0] d, input logic [1:0] resp,
                           input int ar_wait, input int r_wait, input bit hold);
        logic [63:0] exp_addr;
        exp_addr = align8(a);
        @(negedge clk);
        ren = 1'b1; wen = 1'b0; addr = a;
        wdata = {$urandom, $urandom}; wmask = 8'($urandom);
        bus_quiet();
        #1;
        check("ld_c0_stall", stall, 1);
        check("ld_c0_arvalid", bus_if.ar_valid_o, 0);
        for (int k = 0; k <= ar_wait; k++) begin
            @(negedge clk);
            bus_if.ar_ready_i = (k == ar_wait);
            #1;
            check("ld_arvalid", bus_if.ar_valid_o, 1);
            check("ld_araddr", bus_if.ar_addr_o, exp_addr);
            check("ld_ar_stall", stall, 1);
            check("ld_ar_err", err, 0);
        end
        for (int k = 0; k <= r_wait; k++) begin
            @(negedge clk);
            bus_if.ar_ready_i = 1'b0;
            bus_if.r_valid_i  = (k == r_wait);
            bus_if.r_data_i   = (k == r_wait) ? d : {$urandom, $urandom};
            bus_if.r_resp_i   = (k == r_wait) ? resp : 2'b11;
            #1;
            check("ld_rready", bus_if.r_ready_o, 1);
            check("ld_r_arvalid", bus_if.ar_valid_o, 0);
            check("ld_r_stall", stall, 1);
            check("ld_rdata_hold", rdata, m_rdata);
        end
        @(negedge clk);
        bus_quiet();
        if (!hold) ren = 1'b0;
        #1;
        m_rdata = (resp == 2'b00) ? d : 64'd0;
        check("ld_done_stall", stall, 0);
        check("ld_done_err", err, 64'(resp != 2'b00));
        check("ld_done_rdata", rdata, m_rdata);
        check("ld_done_rready", bus_if.r_ready_o, 0);
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                            input int aw_wait, input int w_wait, input int b_wait,
                            input logic [1:0] resp, input bit also_ren, input bit hold);
        int n;
        n = ((aw_wait > w_wait) ? aw_wait : w_wait) + 1;
        @(negedge clk);
        wen = 1'b1; ren = also_ren; addr = a; wdata = d; wmask = m;
        bus_quiet();
        #1;
        check("st_c0_stall", stall, 1);
        check("st_c0_awvalid", bus_if.aw_valid_o, 0);
        check("st_c0_wvalid", bus_if.w_valid_o, 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus_if.aw_ready_i = (k == aw_wait);
            bus_if.w_ready_i  = (k == w_wait);
            #1;
            check("st_awvalid", bus_if.aw_valid_o, 64'(k <= aw_wait));
            check("st_wvalid", bus_if.w_valid_o, 64'(k <= w_wait));
            if (k <= aw_wait) check("st_awaddr", bus_if.aw_addr_o, align8(a));
            if (k <= w_wait) begin
                check("st_wdata", bus_if.w_data_o, place_bytes(d, a));
                check("st_wstrb", bus_if.w_strb_o, m);
            end
            check("st_arvalid", bus_if.ar_valid_o, 0);
            check("st_early_bready", bus_if.b_ready_o, 0);
            check("st_w_stall", stall, 1);
        end
        for (int k = 0; k <= b_wait; k++) begin
            @(negedge clk);
            bus_if.aw_ready_i = 1'b0;
            bus_if.w_ready_i  = 1'b0;
            bus_if.b_valid_i  = (k == b_wait);
            bus_if.b_resp_i   = (k == b_wait) ? resp : 2'b11;
            #1;
            check("st_bready", bus_if.b_ready_o, 1);
            check("st_b_awvalid", bus_if.aw_valid_o, 0);
            check("st_b_wvalid", bus_if.w_valid_o, 0);
            check("st_b_stall", stall, 1);
        end
        @(negedge clk);
        bus_quiet();
        if (!hold) begin
            wen = 1'b0;
            ren = 1'b0;
        end
        #1;
        check("st_done_stall", stall, 0);
        check("st_done_err", err, 64'(resp != 2'b00));
        check("st_done_bready", bus_if.b_ready_o, 0);
        check("st_done_rdata", rdata, m_rdata);
    endtask

    initial begin
        logic [1:0] resp;
        int         r;

        rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; wmask = '0;
        m_rdata = '0;
        bus_quiet();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", stall, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_arvalid", bus_if.ar_valid_o, 0);
        check("rst_awvalid", bus_if.aw_valid_o, 0);
        check("rst_wvalid", bus_if.w_valid_o, 0);
        check("rst_rready", bus_if.r_ready_o, 0);
        check("rst_bready", bus_if.b_ready_o, 0);
        check("rst_araddr", bus_if.ar_addr_o, 0);
        check("rst_wdata", bus_if.w_data_o, 0);
        check("rst_wstrb", bus_if.w_strb_o, 0);

        // directed scenarios
        do_load(64'h8000_0004, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 1'b0);
        do_store(64'h8000_0013, 64'h0000_0000_0000_00AB, 8'h08, 0, 1, 0, 2'b00, 1'b0, 1'b0);
        do_load(64'h8000_0020, 64'hDEAD_BEEF_0BAD_F00D, 2'b00, 5, 0, 1'b0);
        do_load(64'h8000_0028, 64'hFFFF_0000_FFFF_0000, 2'b10, 0, 0, 1'b0);
        do_load(64'h0000_0100, 64'hA5A5_A5A5_0000_0100, 2'b00, 0, 0, 1'b0);
        do_load(64'h0000_0108, 64'h5A5A_5A5A_0000_0108, 2'b00, 0, 0, 1'b0);
        do_store(64'h0000_0207, 64'h0123_4567_89AB_CDEF, 8'hFF, 2, 0, 1, 2'b10, 1'b1, 1'b1);
        idle_gap(2);

        // reset while the read data beat is outstanding
        @(negedge clk);
        ren = 1'b1; addr = 64'h0000_0400; bus_quiet();
        @(negedge clk);
        bus_if.ar_ready_i = 1'b1;
        @(negedge clk);
        bus_if.ar_ready_i = 1'b0;
        #1;
        check("rstmid_rready_before", bus_if.r_ready_o, 1);
        rst = 1'b1;
        ren = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_rdata = '0;
        check("rstmid_rready", bus_if.r_ready_o, 0);
        check("rstmid_arvalid", bus_if.ar_valid_o, 0);
        check("rstmid_rdata", rdata, 0);
        check("rstmid_err", err, 0);
        check("rstmid_stall", stall, 0);

        // randomised traffic
        for (int i = 0; i < 300; i++) begin
            r    = int'($urandom_range(0, 7));
            resp = (r < 5) ? 2'b00 : 2'(r - 4);
            if ($urandom_range(0, 1) == 1)
                do_load({$urandom, $urandom}, {$urandom, $urandom}, resp,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));
            else
                do_store({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), resp,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle_gap(int'($urandom_range(0, 2)));
        end
        idle_gap(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lsu_bus_bridge

`default_nettype wire
